// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder: serves level-held word requests from an
// on-chip array after LATENCY cycles, with a program-write port for boot-time loading.
module imem_responder #(
  parameter int                    MEM_WORDS  = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LATENCY    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  busy,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [15:0]           served_cnt
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // The extra top bit of the difference is the borrow, i.e. addr below BASE_ADDR.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] && ((diff[ADDR_WIDTH-1:0] >> 2) < ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];
  logic [1:0]              r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:2]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_ready;
  logic                    r_err;
  logic                    r_busy;
  logic [15:0]             r_served;

  logic [ADDR_WIDTH-1:0]   w_cap_addr;
  logic                    w_cap_ok;
  logic [IDX_W-1:0]        w_cap_idx;

  // In IDLE the live address is captured directly (LATENCY==1 path), otherwise the latched one.
  assign w_cap_addr = (r_state == S_IDLE) ? mem_addr : {r_addr, 2'b00};
  assign w_cap_ok   = addr_ok(w_cap_addr);
  assign w_cap_idx  = addr_idx(w_cap_addr);

  // Program writes; nonblocking update means a same-edge response capture sees old data.
  always_ff @(posedge clk) begin
    if (prog_we && addr_ok(prog_addr)) begin
      r_mem[addr_idx(prog_addr)] <= prog_data;
    end
  end

  // Request FSM with all outputs registered; response strobes default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_data   <= NOP_WORD;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_served <= 16'd0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= NOP_WORD;
      case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_addr <= mem_addr[ADDR_WIDTH-1:2];
            r_busy <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_err   <= !w_cap_ok;
              r_data  <= w_cap_ok ? r_mem[w_cap_idx] : NOP_WORD;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!mem_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (mem_addr[ADDR_WIDTH-1:2] != r_addr) begin
            r_addr <= mem_addr[ADDR_WIDTH-1:2];
            r_cnt  <= CNT_LOAD;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_err   <= !w_cap_ok;
            r_data  <= w_cap_ok ? r_mem[w_cap_idx] : NOP_WORD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_served <= r_served + 16'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data   = r_data;
  assign mem_ready  = r_ready;
  assign mem_err    = r_err;
  assign busy       = r_busy;
  assign served_cnt = r_served;

endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench for imem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_ready, a_err, a_busy, a_pwe;
  logic [31:0] a_addr, a_data, a_paddr, a_pdata;
  logic [15:0] a_served;
  logic        b_req, b_ready, b_err, b_busy, b_pwe;
  logic [31:0] b_addr, b_data, b_paddr, b_pdata;
  logic [15:0] b_served;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          a_served_exp = 0;
  int          cyc;
  int          pulses;

  imem_responder #(.LATENCY(4)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_req(a_req), .mem_addr(a_addr), .mem_data(a_data),
    .mem_ready(a_ready), .mem_err(a_err), .busy(a_busy), .prog_we(a_pwe),
    .prog_addr(a_paddr), .prog_data(a_pdata), .served_cnt(a_served)
  );

  imem_responder #(.LATENCY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_req(b_req), .mem_addr(b_addr), .mem_data(b_data),
    .mem_ready(b_ready), .mem_err(b_err), .busy(b_busy), .prog_we(b_pwe),
    .prog_addr(b_paddr), .prog_data(b_pdata), .served_cnt(b_served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  // Advance one clock and stop mid-cycle, where inputs are driven and outputs sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic prog(input bit sel, input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      b_pwe = 1'b1; b_paddr = addr; b_pdata = data;
    end else begin
      a_pwe = 1'b1; a_paddr = addr; a_pdata = data;
    end
    step();
    a_pwe = 1'b0;
    b_pwe = 1'b0;
  endtask

  // Pop the next expectation, wait for the strobe (counting cycles from 'start'), compare,
  // then confirm the strobe lasted one cycle and mem_data fell back to NOP.
  task automatic wait_resp(input bit sel, input string tag, input int start);
    exp_t e;
    int   n;
    bit   found;
    e = sb.pop_front();
    n = start;
    found = 1'b0;
    while (!found && n < start + 30) begin
      step();
      n++;
      if (rdy(sel)) found = 1'b1;
    end
    if (!found) begin
      chk({tag, "_timeout"}, {31'd0, rdy(sel)}, 32'd1);
    end else begin
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
      chk({tag, "_data"}, sel ? b_data : a_data, e.data);
      chk({tag, "_err"}, {31'd0, sel ? b_err : a_err}, {31'd0, e.err});
      if (!sel) a_served_exp++;
      step();
      chk({tag, "_pulse1"}, {31'd0, rdy(sel)}, 32'd0);
      chk({tag, "_datanop"}, sel ? b_data : a_data, NOP);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_addr = 32'd0; a_pwe = 1'b0; a_paddr = 32'd0; a_pdata = 32'd0;
    b_req = 1'b0; b_addr = 32'd0; b_pwe = 1'b0; b_paddr = 32'd0; b_pdata = 32'd0;
    @(negedge clk);
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_data", a_data, NOP);
    chk("rst_served", {16'd0, a_served}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    prog(1'b0, 32'h0000_0040, 32'h0050_0093);
    prog(1'b0, 32'h0000_0080, 32'h00A0_0113);
    prog(1'b0, 32'h0000_0FFC, 32'hDEAD_BEEF);

    // Basic fetch of word 0x10.
    a_req = 1'b1; a_addr = 32'h0000_0040;
    sb.push_back('{32'h0050_0093, 1'b0, 4});
    wait_resp(1'b0, "basic", 0);
    a_req = 1'b0;
    chk("basic_served", {16'd0, a_served}, 32'(a_served_exp));
    step();

    // Withdrawn request: no response, back to IDLE by cycle 3.
    a_req = 1'b1; a_addr = 32'h0000_0040;
    step();
    chk("wd_busy1", {31'd0, a_busy}, 32'd1);
    step();
    a_req = 1'b0;
    step();
    chk("wd_idle", {31'd0, a_busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_ready) pulses++;
    end
    chk("wd_nopulse", 32'(pulses), 32'd0);
    chk("wd_served", {16'd0, a_served}, 32'(a_served_exp));

    // Redirect in cycle 2 restarts the latency with the new word.
    a_req = 1'b1; a_addr = 32'h0000_0040;
    step();
    step();
    a_addr = 32'h0000_0080;
    sb.push_back('{32'h00A0_0113, 1'b0, 6});
    wait_resp(1'b0, "redir", 2);
    a_req = 1'b0;
    step();

    // Last in-range word and first out-of-range word.
    a_req = 1'b1; a_addr = 32'h0000_0FFC;
    sb.push_back('{32'hDEAD_BEEF, 1'b0, 4});
    wait_resp(1'b0, "top", 0);
    a_req = 1'b0;
    step();
    a_req = 1'b1; a_addr = 32'h0000_1000;
    sb.push_back('{NOP, 1'b1, 4});
    wait_resp(1'b0, "oor", 0);
    a_req = 1'b0;
    chk("oor_served", {16'd0, a_served}, 32'(a_served_exp));
    step();

    // Program write on the capture edge: response carries the old word, next one the new.
    a_req = 1'b1; a_addr = 32'h0000_0040;
    step(); step(); step();
    a_pwe = 1'b1; a_paddr = 32'h0000_0040; a_pdata = 32'h1111_1111;
    sb.push_back('{32'h0050_0093, 1'b0, 4});
    wait_resp(1'b0, "wcoll", 3);
    a_pwe = 1'b0;
    a_req = 1'b0;
    step();
    a_req = 1'b1;
    sb.push_back('{32'h1111_1111, 1'b0, 4});
    wait_resp(1'b0, "wnew", 0);
    a_req = 1'b0;
    step();

    // LATENCY=1 instance.
    prog(1'b1, 32'h0000_0000, 32'h1234_5678);
    chk("l1_served0", {16'd0, b_served}, 32'd0);
    b_req = 1'b1; b_addr = 32'h0000_0000;
    sb.push_back('{32'h1234_5678, 1'b0, 1});
    wait_resp(1'b1, "l1", 0);
    b_req = 1'b0;
    chk("l1_served1", {16'd0, b_served}, 32'd1);
    step();

    // Reset during WAIT aborts the response.
    a_req = 1'b1; a_addr = 32'h0000_0040;
    step(); step();
    rst_n = 1'b0;
    #1;
    a_served_exp = 0;
    chk("mr_ready", {31'd0, a_ready}, 32'd0);
    chk("mr_busy", {31'd0, a_busy}, 32'd0);
    chk("mr_data", a_data, NOP);
    chk("mr_served", {16'd0, a_served}, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_ready) pulses++;
    end
    chk("mr_nopulse", 32'(pulses), 32'd0);

    // Held request: three responses, each LATENCY+1 = 5 cycles apart.
    a_req = 1'b1; a_addr = 32'h0000_0040;
    for (int k = 0; k < 3; k++) sb.push_back('{32'h1111_1111, 1'b0, 4});
    wait_resp(1'b0, "held0", 0);
    wait_resp(1'b0, "held1", 0);
    wait_resp(1'b0, "held2", 0);
    a_req = 1'b0;
    chk("held_served", {16'd0, a_served}, 32'(a_served_exp));
    chk("held_served3", {16'd0, a_served}, 32'd3);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc > 5000) begin
        $display("FAIL watchdog: observed %0d cycles expected under 5000", cyc);
        $fatal(1, "watchdog");
      end
    end
  end

endmodule
